// File: rtl/axi_wr_burst_splitter.sv
// AXI3 write-channel front end: buffers W beats, splits AW bursts into single-beat commands
// and returns one B response per burst. Define AXI_WR_LAST_CHECK_EN to flag WLAST mismatches.
module axi_wr_burst_splitter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [DATA_W-1:0]   cmd_wdata,
  output logic [DATA_W/8-1:0] cmd_wstrb,
  output logic [2:0]          cmd_size,
  output logic                cmd_last,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  input  logic                done_valid,
  input  logic                done_err
);

  localparam int unsigned StrbW  = DATA_W / 8;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = DATA_W + StrbW + 1;
  localparam logic [2:0]  MaxSize = 3'($clog2(StrbW));
  localparam logic [PtrW:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StData, StWait, StResp} state_e;

  // W beat FIFO; entry = {wlast, wstrb, wdata}
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [EntryW-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full, push, pop;
  logic [EntryW-1:0] head;
  logic              head_last;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign WREADY     = ~fifo_full;
  assign push       = WVALID & ~fifo_full;
  assign head       = mem_q[rd_ptr_q[PtrW-1:0]];
  assign head_last  = head[EntryW-1];
  assign cmd_wdata  = head[DATA_W-1:0];
  assign cmd_wstrb  = head[DATA_W+StrbW-1:DATA_W];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = {WLAST, WSTRB, WDATA};
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Burst control
  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [8:0]          done_cnt_q, done_cnt_d;
  logic                err_q, err_d;
  logic                discard_q, discard_d;
  logic                last_beat, aw_illegal;
  logic [8:0]          len_plus1;
  logic [ADDR_W-1:0]   bytes, span_mask, addr_inc, addr_next;

  assign last_beat = (beat_cnt_q == len_q);
  assign len_plus1 = {1'b0, len_q} + 9'd1;
  assign pop       = (state_q == StData) & ~fifo_empty & (discard_q | cmd_ready);
  assign cmd_addr  = addr_q;
  assign cmd_size  = size_q;
  assign BID       = id_q;

  assign aw_illegal = (AWBURST == 2'b11) || (AWSIZE > MaxSize) || (AWLEN > 8'd15) ||
                      ((AWBURST == 2'b10) && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign bytes     = ADDR_W'(1) << size_q;
  assign span_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
  assign addr_inc  = addr_q + bytes;

  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      2'b01:   addr_next = addr_inc;
      2'b10:   addr_next = (addr_q & ~span_mask) | (addr_inc & span_mask);
      default: addr_next = addr_q;
    endcase
  end

`ifndef AXI_WR_LAST_CHECK_EN
  logic unused_head_last;
  assign unused_head_last = head_last;
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    done_cnt_d = done_cnt_q;
    err_d      = err_q;
    discard_d  = discard_q;
    AWREADY    = 1'b0;
    BVALID     = 1'b0;
    BRESP      = 2'b00;
    cmd_valid  = 1'b0;
    cmd_last   = 1'b0;

    // Discarded beats complete immediately, alongside any real done pulse
    if (state_q inside {StData, StWait}) begin
      done_cnt_d = done_cnt_q + 9'(done_valid) + 9'(pop & discard_q);
      if (done_valid && done_err) err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        AWREADY = ~ARESET;
        if (AWVALID && !ARESET) begin
          id_d       = AWID;
          addr_d     = AWADDR;
          len_d      = AWLEN;
          size_d     = AWSIZE;
          burst_d    = AWBURST;
          beat_cnt_d = '0;
          done_cnt_d = '0;
          err_d      = aw_illegal;
          discard_d  = aw_illegal;
          state_d    = StData;
        end
      end
      StData: begin
        cmd_valid = ~fifo_empty & ~discard_q;
        cmd_last  = last_beat;
        if (pop) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          addr_d     = addr_next;
`ifdef AXI_WR_LAST_CHECK_EN
          if (head_last != last_beat) err_d = 1'b1;
`endif
          if (last_beat) state_d = StWait;
        end
      end
      StWait: begin
        if (done_cnt_d == len_plus1) state_d = StResp;
      end
      StResp: begin
        BVALID = 1'b1;
        BRESP  = err_q ? 2'b10 : 2'b00;
        if (BREADY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// Directed self-checking bench for axi_wr_burst_splitter with an auto-responding AHB side.
module tb_axi_wr_burst_splitter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_size;
  logic        cmd_last;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        done_valid = 1'b0;
  logic        done_err = 1'b0;

  axi_wr_burst_splitter #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .FIFO_DEPTH(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_size(cmd_size),
    .cmd_last(cmd_last), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done_valid(done_valid), .done_err(done_err)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_cyc[$];
  int          cmd_cnt = 0;
  int          b_cnt = 0;
  int          aw_cyc = 0;
  int          b_cyc = 0;
  logic [1:0]  b_resp = '0;
  logic [3:0]  b_id = '0;
  bit          done_pend = 0;
  bit          done_pend_err = 0;
  bit          hold_done = 0;
  int          err_beat = -1;
  int          beat_idx = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Observe handshakes mid-cycle, away from the active edge
  initial forever begin
    @(negedge ACLK);
    if (!ARESET) begin
      if (cmd_valid && cmd_ready) begin
        q_addr.push_back(cmd_addr);
        q_data.push_back(cmd_wdata);
        q_last.push_back(cmd_last);
        q_cyc.push_back(cyc);
        cmd_cnt++;
        if (!hold_done) begin
          done_pend = 1'b1;
          done_pend_err = (beat_idx == err_beat);
        end
        beat_idx = cmd_last ? 0 : beat_idx + 1;
      end
      if (BVALID && BREADY) begin
        b_cnt++;
        b_resp = BRESP;
        b_id = BID;
        b_cyc = cyc;
      end
      if (AWVALID && AWREADY) aw_cyc = cyc;
    end
  end

  // Each accepted command completes one cycle after its handshake
  initial forever begin
    @(posedge ACLK);
    #1;
    done_valid = done_pend;
    done_err = done_pend & done_pend_err;
    done_pend = 1'b0;
    done_pend_err = 1'b0;
  end

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  task automatic push_w(input int n, input logic [31:0] base, input int last_idx);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      WVALID = 1'b1;
      WDATA = base + 32'(i);
      WSTRB = 4'hF;
      WLAST = (i == last_idx);
      for (int t = 0; t < 50; t++) begin
        @(negedge ACLK);
        if (WREADY) begin
          ok = 1;
          break;
        end
        @(posedge ACLK);
        #1;
      end
      if (!ok) check_eq("w_timeout", 64'(WREADY), 64'd1);
      @(posedge ACLK);
      #1;
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    AWID = id;
    AWADDR = addr;
    AWLEN = len;
    AWSIZE = size;
    AWBURST = burst;
    AWVALID = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge ACLK);
      if (AWREADY) break;
      @(posedge ACLK);
      #1;
    end
    check_eq("awready", 64'(AWREADY), 64'd1);
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
  endtask

  task automatic wait_b(input string tag);
    int start = b_cnt;
    for (int t = 0; t < 200 && b_cnt == start; t++) begin
      @(posedge ACLK);
      #1;
    end
    check_eq({tag, "_bcnt"}, 64'(b_cnt - start), 64'd1);
  endtask

  task automatic check_cmd(input string tag, input int idx, input logic [31:0] addr,
                           input logic [31:0] data, input logic last);
    check_eq({tag, "_addr"}, 64'(q_addr[idx]), 64'(addr));
    check_eq({tag, "_data"}, 64'(q_data[idx]), 64'(data));
    check_eq({tag, "_last"}, 64'(q_last[idx]), 64'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    check_eq("rst_awready", 64'(AWREADY), 64'd0);
    check_eq("rst_wready", 64'(WREADY), 64'd1);
    check_eq("rst_bvalid", 64'(BVALID), 64'd0);
    check_eq("rst_bresp", 64'(BRESP), 64'd0);
    check_eq("rst_bid", 64'(BID), 64'd0);
    check_eq("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check_eq("rst_cmd_last", 64'(cmd_last), 64'd0);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    check_eq("idle_awready", 64'(AWREADY), 64'd1);

    // INCR, 4 beats
    clear_q();
    push_w(4, 32'hA000_0000, 3);
    send_aw(4'd5, 32'h1000, 8'd3, 3'd2, 2'b01);
    wait_b("incr");
    check_eq("incr_ncmd", 64'(q_addr.size()), 64'd4);
    check_cmd("incr0", 0, 32'h1000, 32'hA000_0000, 1'b0);
    check_cmd("incr1", 1, 32'h1004, 32'hA000_0001, 1'b0);
    check_cmd("incr2", 2, 32'h1008, 32'hA000_0002, 1'b0);
    check_cmd("incr3", 3, 32'h100C, 32'hA000_0003, 1'b1);
    check_eq("incr_bresp", 64'(b_resp), 64'd0);
    check_eq("incr_bid", 64'(b_id), 64'd5);

    // Single beat, minimum latency
    clear_q();
    push_w(1, 32'hB000_0000, 0);
    send_aw(4'd3, 32'h0500, 8'd0, 3'd2, 2'b01);
    wait_b("lat");
    check_eq("lat_ncmd", 64'(q_addr.size()), 64'd1);
    check_cmd("lat0", 0, 32'h0500, 32'hB000_0000, 1'b1);
    check_eq("lat_cmd_cyc", 64'(q_cyc[0] - aw_cyc), 64'd1);
    check_eq("lat_b_cyc", 64'(b_cyc - aw_cyc), 64'd3);
    check_eq("lat_bid", 64'(b_id), 64'd3);

    // WRAP, 4 beats of 4 bytes, wraps inside 0x1030..0x103F
    clear_q();
    push_w(4, 32'hC000_0000, 3);
    send_aw(4'd6, 32'h1038, 8'd3, 3'd2, 2'b10);
    wait_b("wrap");
    check_eq("wrap_ncmd", 64'(q_addr.size()), 64'd4);
    check_eq("wrap_a0", 64'(q_addr[0]), 64'h1038);
    check_eq("wrap_a1", 64'(q_addr[1]), 64'h103C);
    check_eq("wrap_a2", 64'(q_addr[2]), 64'h1030);
    check_eq("wrap_a3", 64'(q_addr[3]), 64'h1034);
    check_eq("wrap_bresp", 64'(b_resp), 64'd0);

    // FIXED with an error on beat 1
    clear_q();
    err_beat = 1;
    push_w(2, 32'hE000_0000, 1);
    send_aw(4'd1, 32'h2000, 8'd1, 3'd2, 2'b00);
    wait_b("fixed");
    err_beat = -1;
    check_eq("fixed_ncmd", 64'(q_addr.size()), 64'd2);
    check_eq("fixed_a0", 64'(q_addr[0]), 64'h2000);
    check_eq("fixed_a1", 64'(q_addr[1]), 64'h2000);
    check_eq("fixed_bresp", 64'(b_resp), 64'd2);

    // Reserved burst type: beats drained silently
    clear_q();
    push_w(2, 32'hF000_0000, 1);
    send_aw(4'd2, 32'h0100, 8'd1, 3'd2, 2'b11);
    wait_b("rsvd");
    check_eq("rsvd_ncmd", 64'(q_addr.size()), 64'd0);
    check_eq("rsvd_bresp", 64'(b_resp), 64'd2);

    // Oversized beat
    clear_q();
    push_w(1, 32'hF100_0000, 0);
    send_aw(4'd2, 32'h0100, 8'd0, 3'd3, 2'b01);
    wait_b("size");
    check_eq("size_ncmd", 64'(q_addr.size()), 64'd0);
    check_eq("size_bresp", 64'(b_resp), 64'd2);

    // WRAP with illegal length 3 beats
    clear_q();
    push_w(3, 32'hF200_0000, 2);
    send_aw(4'd2, 32'h0100, 8'd2, 3'd2, 2'b10);
    wait_b("wlen");
    check_eq("wlen_ncmd", 64'(q_addr.size()), 64'd0);
    check_eq("wlen_bresp", 64'(b_resp), 64'd2);
    check_eq("wlen_wready", 64'(WREADY), 64'd1);

    // W leads AW and fills the FIFO
    clear_q();
    push_w(4, 32'hD000_0000, 3);
    check_eq("full_wready", 64'(WREADY), 64'd0);
    send_aw(4'd9, 32'h3000, 8'd3, 3'd2, 2'b01);
    wait_b("lead");
    check_eq("lead_ncmd", 64'(q_addr.size()), 64'd4);
    check_cmd("lead0", 0, 32'h3000, 32'hD000_0000, 1'b0);
    check_cmd("lead3", 3, 32'h300C, 32'hD000_0003, 1'b1);
    check_eq("lead_bresp", 64'(b_resp), 64'd0);
    check_eq("lead_bid", 64'(b_id), 64'd9);

    // Reset while waiting for completions, with a stray beat in the FIFO
    clear_q();
    hold_done = 1;
    push_w(2, 32'h5000_0000, 1);
    send_aw(4'd2, 32'h4000, 8'd1, 3'd2, 2'b01);
    for (int t = 0; t < 50 && q_addr.size() < 2; t++) begin
      @(posedge ACLK);
      #1;
    end
    check_eq("rstw_ncmd", 64'(q_addr.size()), 64'd2);
    push_w(1, 32'hDEAD_0000, 0);
    check_eq("rstw_no_b", 64'(BVALID), 64'd0);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    hold_done = 0;
    beat_idx = 0;
    check_eq("rstw_bvalid", 64'(BVALID), 64'd0);
    check_eq("rstw_cmd_valid", 64'(cmd_valid), 64'd0);
    check_eq("rstw_wready", 64'(WREADY), 64'd1);
    clear_q();
    push_w(1, 32'h6000_0000, 0);
    send_aw(4'd7, 32'h6000, 8'd0, 3'd2, 2'b01);
    wait_b("post");
    check_eq("post_ncmd", 64'(q_addr.size()), 64'd1);
    check_cmd("post0", 0, 32'h6000, 32'h6000_0000, 1'b1);
    check_eq("post_bresp", 64'(b_resp), 64'd0);
    check_eq("post_bid", 64'(b_id), 64'd7);

    // WLAST asserted early on beat 2 of 4
    clear_q();
    push_w(4, 32'h7000_0000, 1);
    send_aw(4'd4, 32'h7000, 8'd3, 3'd2, 2'b01);
    wait_b("wlast");
    check_eq("wlast_ncmd", 64'(q_addr.size()), 64'd4);
    check_eq("wlast_last1", 64'(q_last[1]), 64'd0);
    check_eq("wlast_last3", 64'(q_last[3]), 64'd1);
`ifdef AXI_WR_LAST_CHECK_EN
    check_eq("wlast_bresp", 64'(b_resp), 64'd2);
`else
    check_eq("wlast_bresp", 64'(b_resp), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
